id_stage_pipe_reg_nlane: RTL and testbench

- Parametrised ID1->ID2 pipeline register for the N-wide issue front end; generalises the fixed two-lane, fixed-width stage register.
- Carries a per-lane valid bit, an opaque decoded payload (instruction plus control bits) and PC-derived fields per lane.
- Adds true hold (stall keeps contents), bubble insertion, per-lane and age-ordered flush with a fixed priority, and saturating event counters for perf monitoring.
- Sits between the decode-1 outputs and the decode-2/hazard logic.

---
 rtl/id_pipe_pkg.sv | 33 +++
 rtl/id_pipe_lane.sv | 90 +++++++++
 rtl/id_stage_pipe_reg_nlane.sv | 129 ++++++++++++
 tb/tb_id_stage_pipe_reg_nlane.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pipe_pkg.sv
// Shared types and helpers for the N-lane ID1->ID2 pipeline register.
package id_pipe_pkg;

   localparam int DEF_LANES     = 2;
   localparam int DEF_PAYLOAD_W = 48;
   localparam int DEF_PC_W      = 8;
   localparam int MAX_LANES     = 32;

   // Per-lane register decision made by the stage controller.
   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      HOLD  = 2'd1,
      CLEAR = 2'd2
   } lane_ctl_t;

   // Lane i dies on a global flush, its own flush, or a younger-flush
   // raised at any lane at or older than i (running OR from lane 0 up).
   function automatic logic [MAX_LANES-1:0] age_kill_mask(
      input logic                 flush_all,
      input logic [MAX_LANES-1:0] flush_lane,
      input logic [MAX_LANES-1:0] flush_younger
   );
      logic [MAX_LANES-1:0] mask;
      logic                 acc;
      acc = flush_all;
      for (int i = 0; i < MAX_LANES; i++) begin
         acc     = acc | flush_younger[i];
         mask[i] = acc | flush_lane[i];
      end
      return mask;
   endfunction

endpackage

// File: rtl/id_pipe_lane.sv
// One lane of the ID1->ID2 register: valid, payload, PC fields, prediction.
module id_pipe_lane
   import id_pipe_pkg::*;
#(
   parameter int PAYLOAD_W    = DEF_PAYLOAD_W,
   parameter int PC_W         = DEF_PC_W,
   parameter bit ZERO_INVALID = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  lane_ctl_t            ctl,
   input  logic                 in_valid,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic [PC_W-1:0]      in_pc,
   input  logic [PC_W-1:0]      in_pc_plus1,
   input  logic [PC_W-1:0]      in_pc_branch,
   input  logic                 in_pred,
   output logic                 out_valid,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [PC_W-1:0]      out_pc,
   output logic [PC_W-1:0]      out_pc_plus1,
   output logic [PC_W-1:0]      out_pc_branch,
   output logic                 out_pred
);

   logic                 valid_q,     valid_d;
   logic [PAYLOAD_W-1:0] payload_q,   payload_d;
   logic [PC_W-1:0]      pc_q,        pc_d;
   logic [PC_W-1:0]      pc_plus1_q,  pc_plus1_d;
   logic [PC_W-1:0]      pc_branch_q, pc_branch_d;
   logic                 pred_q,      pred_d;

   // Next-state select: load, keep, or squash (optionally scrubbing data).
   always_comb begin
      valid_d     = valid_q;
      payload_d   = payload_q;
      pc_d        = pc_q;
      pc_plus1_d  = pc_plus1_q;
      pc_branch_d = pc_branch_q;
      pred_d      = pred_q;
      case (ctl)
         LOAD: begin
            valid_d     = in_valid;
            payload_d   = in_payload;
            pc_d        = in_pc;
            pc_plus1_d  = in_pc_plus1;
            pc_branch_d = in_pc_branch;
            pred_d      = in_pred;
         end
         CLEAR: begin
            valid_d = 1'b0;
            if (ZERO_INVALID) begin
               payload_d   = '0;
               pc_d        = '0;
               pc_plus1_d  = '0;
               pc_branch_d = '0;
               pred_d      = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Lane registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q     <= 1'b0;
         payload_q   <= '0;
         pc_q        <= '0;
         pc_plus1_q  <= '0;
         pc_branch_q <= '0;
         pred_q      <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         payload_q   <= payload_d;
         pc_q        <= pc_d;
         pc_plus1_q  <= pc_plus1_d;
         pc_branch_q <= pc_branch_d;
         pred_q      <= pred_d;
      end
   end

   assign out_valid     = valid_q;
   assign out_payload   = payload_q;
   assign out_pc        = pc_q;
   assign out_pc_plus1  = pc_plus1_q;
   assign out_pc_branch = pc_branch_q;
   assign out_pred      = pred_q;

endmodule

// File: rtl/id_stage_pipe_reg_nlane.sv
// N-lane ID1->ID2 pipeline register: flush/hold/bubble control per lane,
// plus saturating bubble and kill counters.
module id_stage_pipe_reg_nlane
   import id_pipe_pkg::*;
#(
   parameter int LANES        = DEF_LANES,
   parameter int PAYLOAD_W    = DEF_PAYLOAD_W,
   parameter int PC_W         = DEF_PC_W,
   parameter bit ZERO_INVALID = 1'b1,
   parameter int CNT_W        = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [LANES-1:0]           in_valid,
   input  logic [LANES*PAYLOAD_W-1:0] in_payload,
   input  logic [LANES*PC_W-1:0]      in_pc,
   input  logic [LANES*PC_W-1:0]      in_pc_plus1,
   input  logic [LANES*PC_W-1:0]      in_pc_branch,
   input  logic [LANES-1:0]           in_pred,
   input  logic                       flush_all,
   input  logic [LANES-1:0]           flush_lane,
   input  logic [LANES-1:0]           flush_younger,
   input  logic                       hold,
   input  logic                       bubble,
   input  logic                       clr_counters,
   output logic [LANES-1:0]           out_valid,
   output logic [LANES*PAYLOAD_W-1:0] out_payload,
   output logic [LANES*PC_W-1:0]      out_pc,
   output logic [LANES*PC_W-1:0]      out_pc_plus1,
   output logic [LANES*PC_W-1:0]      out_pc_branch,
   output logic [LANES-1:0]           out_pred,
   output logic [CNT_W-1:0]           bubble_count,
   output logic [CNT_W-1:0]           kill_count
);

   localparam int         SUM_W   = CNT_W + 6;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [MAX_LANES-1:0] flush_lane_ext;
   logic [MAX_LANES-1:0] flush_younger_ext;
   logic [MAX_LANES-1:0] kill_full;
   logic [LANES-1:0]     kill;
   lane_ctl_t            lane_ctl [LANES];
   logic                 unused_kill;

   logic [CNT_W-1:0]     bubble_count_q, bubble_count_d;
   logic [CNT_W-1:0]     kill_count_q,   kill_count_d;
   logic [5:0]           kill_pop;
   logic [SUM_W-1:0]     kill_sum;

   // Age-ordered kill mask and per-lane priority: kill > hold > bubble > load.
   always_comb begin
      flush_lane_ext                = '0;
      flush_younger_ext             = '0;
      flush_lane_ext[LANES-1:0]     = flush_lane;
      flush_younger_ext[LANES-1:0]  = flush_younger;
      kill_full = age_kill_mask(flush_all, flush_lane_ext, flush_younger_ext);
      kill      = kill_full[LANES-1:0];
      for (int i = 0; i < LANES; i++) begin
         lane_ctl[i] = LOAD;
         if (kill[i])     lane_ctl[i] = CLEAR;
         else if (hold)   lane_ctl[i] = HOLD;
         else if (bubble) lane_ctl[i] = CLEAR;
      end
   end

   assign unused_kill = ^kill_full;

   // Counter next-state: clear wins, otherwise saturating increments.
   always_comb begin
      kill_pop = '0;
      for (int i = 0; i < LANES; i++) begin
         kill_pop = kill_pop + 6'(in_valid[i] & kill[i]);
      end
      kill_sum = SUM_W'(kill_count_q) + SUM_W'(kill_pop);

      bubble_count_d = bubble_count_q;
      kill_count_d   = kill_count_q;
      if (clr_counters) begin
         bubble_count_d = '0;
         kill_count_d   = '0;
      end else begin
         if (bubble && !hold && !flush_all && (bubble_count_q != CNT_MAX)) begin
            bubble_count_d = bubble_count_q + 1'b1;
         end
         if (kill_sum[SUM_W-1:CNT_W] != '0) kill_count_d = CNT_MAX;
         else                               kill_count_d = kill_sum[CNT_W-1:0];
      end
   end

   // Perf counter registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         bubble_count_q <= '0;
         kill_count_q   <= '0;
      end else begin
         bubble_count_q <= bubble_count_d;
         kill_count_q   <= kill_count_d;
      end
   end

   assign bubble_count = bubble_count_q;
   assign kill_count   = kill_count_q;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      id_pipe_lane #(
         .PAYLOAD_W    (PAYLOAD_W),
         .PC_W         (PC_W),
         .ZERO_INVALID (ZERO_INVALID)
      ) u_lane (
         .clk           (clk),
         .reset         (reset),
         .ctl           (lane_ctl[g]),
         .in_valid      (in_valid[g]),
         .in_payload    (in_payload[g*PAYLOAD_W +: PAYLOAD_W]),
         .in_pc         (in_pc[g*PC_W +: PC_W]),
         .in_pc_plus1   (in_pc_plus1[g*PC_W +: PC_W]),
         .in_pc_branch  (in_pc_branch[g*PC_W +: PC_W]),
         .in_pred       (in_pred[g]),
         .out_valid     (out_valid[g]),
         .out_payload   (out_payload[g*PAYLOAD_W +: PAYLOAD_W]),
         .out_pc        (out_pc[g*PC_W +: PC_W]),
         .out_pc_plus1  (out_pc_plus1[g*PC_W +: PC_W]),
         .out_pc_branch (out_pc_branch[g*PC_W +: PC_W]),
         .out_pred      (out_pred[g])
      );
   end

endmodule

// File: tb/tb_id_stage_pipe_reg_nlane.sv
// Scoreboard bench: a 2-lane instance (CNT_W=4, ZERO_INVALID=1) and a
// 4-lane instance (PAYLOAD_W=16, ZERO_INVALID=0).
module tb_id_stage_pipe_reg_nlane;

   typedef struct packed {
      logic [3:0]   valid;
      logic [191:0] payload;
      logic [31:0]  pc;
      logic [31:0]  pcp1;
      logic [31:0]  pcb;
      logic [3:0]   pred;
   } bundle_t;

   typedef struct packed {
      logic [3:0] sel;
      bundle_t    exp;
      logic [15:0] bc;
      logic [15:0] kc;
   } entry_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 2-lane DUT signals
   logic        r2 = 1'b0, fa2 = 1'b0, h2 = 1'b0, b2 = 1'b0, c2 = 1'b0;
   logic [1:0]  iv2 = '0, ipr2 = '0, fl2 = '0, fy2 = '0;
   logic [95:0] ip2 = '0;
   logic [15:0] ipc2 = '0, ipp2 = '0, ipb2 = '0;
   logic [1:0]  ov2, opr2;
   logic [95:0] op2;
   logic [15:0] opc2, opp2, opb2;
   logic [3:0]  bc2, kc2;

   // 4-lane DUT signals
   logic        r4 = 1'b0, fa4 = 1'b0, h4 = 1'b0, b4 = 1'b0, c4 = 1'b0;
   logic [3:0]  iv4 = '0, ipr4 = '0, fl4 = '0, fy4 = '0;
   logic [63:0] ip4 = '0;
   logic [31:0] ipc4 = '0, ipp4 = '0, ipb4 = '0;
   logic [3:0]  ov4, opr4;
   logic [63:0] op4;
   logic [31:0] opc4, opp4, opb4;
   logic [15:0] bc4, kc4;

   id_stage_pipe_reg_nlane #(.LANES(2), .PAYLOAD_W(48), .PC_W(8),
                             .ZERO_INVALID(1'b1), .CNT_W(4)) dut2 (
      .clk(clk), .reset(r2), .in_valid(iv2), .in_payload(ip2), .in_pc(ipc2),
      .in_pc_plus1(ipp2), .in_pc_branch(ipb2), .in_pred(ipr2),
      .flush_all(fa2), .flush_lane(fl2), .flush_younger(fy2), .hold(h2),
      .bubble(b2), .clr_counters(c2), .out_valid(ov2), .out_payload(op2),
      .out_pc(opc2), .out_pc_plus1(opp2), .out_pc_branch(opb2),
      .out_pred(opr2), .bubble_count(bc2), .kill_count(kc2));

   id_stage_pipe_reg_nlane #(.LANES(4), .PAYLOAD_W(16), .PC_W(8),
                             .ZERO_INVALID(1'b0), .CNT_W(16)) dut4 (
      .clk(clk), .reset(r4), .in_valid(iv4), .in_payload(ip4), .in_pc(ipc4),
      .in_pc_plus1(ipp4), .in_pc_branch(ipb4), .in_pred(ipr4),
      .flush_all(fa4), .flush_lane(fl4), .flush_younger(fy4), .hold(h4),
      .bubble(b4), .clr_counters(c4), .out_valid(ov4), .out_payload(op4),
      .out_pc(opc4), .out_pc_plus1(opp4), .out_pc_branch(opb4),
      .out_pred(opr4), .bubble_count(bc4), .kill_count(kc4));

   int     tests = 0;
   int     fails = 0;
   entry_t sb_q[$];

   // control values applied by the next step
   logic       c_rst, c_fa, c_hold, c_bub, c_clr;
   logic [3:0] c_fl, c_fy;

   function automatic bundle_t mk(input logic [3:0] v, input logic [191:0] p,
                                  input logic [31:0] pc, input logic [31:0] pp,
                                  input logic [31:0] pb, input logic [3:0] pr);
      bundle_t b;
      b.valid = v; b.payload = p; b.pc = pc; b.pcp1 = pp; b.pcb = pb; b.pred = pr;
      return b;
   endfunction

   task automatic idle();
      c_rst = 1'b1; c_fa = 1'b0; c_hold = 1'b0; c_bub = 1'b0; c_clr = 1'b0;
      c_fl = '0; c_fy = '0;
   endtask

   task automatic step(input int sel, input bundle_t b, input bundle_t e,
                       input int bc, input int kc);
      entry_t en;
      @(negedge clk);
      if (sel == 2) begin
         r2 = c_rst; fa2 = c_fa; h2 = c_hold; b2 = c_bub; c2 = c_clr;
         fl2 = c_fl[1:0]; fy2 = c_fy[1:0];
         iv2 = b.valid[1:0]; ip2 = b.payload[95:0]; ipc2 = b.pc[15:0];
         ipp2 = b.pcp1[15:0]; ipb2 = b.pcb[15:0]; ipr2 = b.pred[1:0];
      end else begin
         r4 = c_rst; fa4 = c_fa; h4 = c_hold; b4 = c_bub; c4 = c_clr;
         fl4 = c_fl; fy4 = c_fy;
         iv4 = b.valid; ip4 = b.payload[63:0]; ipc4 = b.pc;
         ipp4 = b.pcp1; ipb4 = b.pcb; ipr4 = b.pred;
      end
      en.sel = 4'(sel); en.exp = e; en.bc = 16'(bc); en.kc = 16'(kc);
      sb_q.push_back(en);
      @(posedge clk);
   endtask

   task automatic chk(input string name, input int sel,
                      input logic [191:0] act, input logic [191:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d t=%0t got %h expected %h", name, sel, $time, act, exp);
      end
   endtask

   // Monitor: one registered output per edge, compared against the queue head.
   initial begin
      entry_t  en;
      bundle_t a;
      logic [15:0] abc, akc;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            en = sb_q.pop_front();
            a  = '0;
            if (en.sel == 4'd2) begin
               a.valid[1:0] = ov2; a.payload[95:0] = op2; a.pc[15:0] = opc2;
               a.pcp1[15:0] = opp2; a.pcb[15:0] = opb2; a.pred[1:0] = opr2;
               abc = 16'(bc2); akc = 16'(kc2);
            end else begin
               a.valid = ov4; a.payload[63:0] = op4; a.pc = opc4;
               a.pcp1 = opp4; a.pcb = opb4; a.pred = opr4;
               abc = bc4; akc = kc4;
            end
            chk("valid",        int'(en.sel), 192'(a.valid),   192'(en.exp.valid));
            chk("payload",      int'(en.sel), a.payload,       en.exp.payload);
            chk("pc",           int'(en.sel), 192'(a.pc),      192'(en.exp.pc));
            chk("pc_plus1",     int'(en.sel), 192'(a.pcp1),    192'(en.exp.pcp1));
            chk("pc_branch",    int'(en.sel), 192'(a.pcb),     192'(en.exp.pcb));
            chk("pred",         int'(en.sel), 192'(a.pred),    192'(en.exp.pred));
            chk("bubble_count", int'(en.sel), 192'(abc),       192'(en.bc));
            chk("kill_count",   int'(en.sel), 192'(akc),       192'(en.kc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      bundle_t z, ba, bcd, bcd_l0, ba_l0;
      bundle_t e, f, e_s2, e_s3, e_s4, e_s4v;
      int      exp_bc;

      z   = '0;
      ba  = mk(4'b0011, {48'hB0B0_0000_0002, 48'hA0A0_0000_0001},
               {8'h21, 8'h11}, {8'h22, 8'h12}, {8'h40, 8'h30}, 4'b0010);
      bcd = mk(4'b0011, {48'hD0D0_0000_0004, 48'hC0C0_0000_0003},
               {8'h61, 8'h51}, {8'h62, 8'h52}, {8'h80, 8'h70}, 4'b0001);
      bcd_l0 = bcd; bcd_l0.valid = 4'b0001;
      ba_l0  = mk(4'b0001, {48'h0, 48'hA0A0_0000_0001},
                  {8'h00, 8'h11}, {8'h00, 8'h12}, {8'h00, 8'h30}, 4'b0000);

      // ---------------- 2-lane instance ----------------
      idle(); c_rst = 1'b0; c_hold = 1'b1; c_fa = 1'b1; c_bub = 1'b1;
      step(2, ba, z, 0, 0);                     // reset beats hold/flush/bubble
      idle(); c_rst = 1'b0;
      step(2, ba, z, 0, 0);
      idle();
      step(2, ba, ba, 0, 0);                    // first load after reset
      c_hold = 1'b1;
      for (int i = 0; i < 3; i++) step(2, bcd, ba, 0, 0);
      idle();
      step(2, bcd, bcd, 0, 0);                  // hold released
      c_bub = 1'b1;
      step(2, ba, z, 1, 0);                     // bubble zeroes lanes
      idle();
      step(2, ba, ba, 1, 0);
      c_bub = 1'b1; c_hold = 1'b1;
      step(2, bcd, ba, 1, 0);                   // hold beats bubble
      idle(); c_hold = 1'b1; c_fa = 1'b1;
      step(2, bcd, z, 1, 2);                    // flush beats hold, counts kills
      idle();
      step(2, bcd_l0, bcd_l0, 1, 2);            // invalid lane loads unmasked data
      c_fl = 4'b0010; c_fy = 4'b0010;
      step(2, ba, ba_l0, 1, 3);                 // lane + younger flush on lane 1
      idle(); c_bub = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         exp_bc = (1 + i > 15) ? 15 : 1 + i;
         step(2, ba, z, exp_bc, 3);             // saturates at 15
      end
      c_clr = 1'b1;
      step(2, ba, z, 0, 0);                     // clear beats increment
      idle(); c_bub = 1'b1; c_fa = 1'b1;
      step(2, ba, z, 0, 2);                     // flush_all suppresses bubble count
      idle(); c_bub = 1'b1;
      step(2, ba, z, 1, 2);

      // ---------------- 4-lane instance ----------------
      e = mk(4'b1111, {16'h1003, 16'h1002, 16'h1001, 16'h1000},
             {8'h13, 8'h12, 8'h11, 8'h10}, {8'h23, 8'h22, 8'h21, 8'h20},
             {8'h33, 8'h32, 8'h31, 8'h30}, 4'b0101);
      f = mk(4'b1111, {16'h2003, 16'h2002, 16'h2001, 16'h2000},
             {8'h43, 8'h42, 8'h41, 8'h40}, {8'h53, 8'h52, 8'h51, 8'h50},
             {8'h63, 8'h62, 8'h61, 8'h60}, 4'b1010);
      e_s2 = mk(4'b0001, {16'h1003, 16'h1002, 16'h1001, 16'h2000},
                {8'h13, 8'h12, 8'h11, 8'h40}, {8'h23, 8'h22, 8'h21, 8'h50},
                {8'h33, 8'h32, 8'h31, 8'h60}, 4'b0100);
      e_s3 = mk(4'b1011, {16'h2003, 16'h1002, 16'h2001, 16'h2000},
                {8'h43, 8'h12, 8'h41, 8'h40}, {8'h53, 8'h22, 8'h51, 8'h50},
                {8'h63, 8'h32, 8'h61, 8'h60}, 4'b1110);
      e_s4 = mk(4'b0111, {16'h2003, 16'h1002, 16'h1001, 16'h1000},
                {8'h43, 8'h12, 8'h11, 8'h10}, {8'h53, 8'h22, 8'h21, 8'h20},
                {8'h63, 8'h32, 8'h31, 8'h30}, 4'b1101);
      e_s4v = e; e_s4v.valid = 4'b0111;

      idle(); c_rst = 1'b0;
      step(4, e, z, 0, 0);
      idle();
      step(4, e, e, 0, 0);
      c_fy = 4'b0010;
      step(4, f, e_s2, 0, 3);                   // lanes 1..3 killed, data kept
      idle(); c_fl = 4'b0100;
      step(4, f, e_s3, 0, 4);                   // lane 2 only
      idle(); c_fy = 4'b1000;
      step(4, e_s4v, e_s4, 0, 4);               // killed lane was invalid: no count
      idle(); c_hold = 1'b1; c_fa = 1'b1;
      e_s4.valid = 4'b0000;
      step(4, f, e_s4, 0, 8);                   // flush beats hold
      idle(); c_fy = 4'b0001;
      step(4, f, e_s4, 0, 12);                  // younger[0] acts as flush_all

      idle();
      repeat (3) @(posedge clk);
      #2;
      tests++;
      if (sb_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain got %0d entries expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
